// File: rtl/bram_wrapper_pipe.sv
// bram_wrapper_pipe: simple-dual-port BRAM wrapper, lane strobes, N-deep read pipe.
// Ports: clk; reset (async, active-low); w_valid/w_address/w_strb/w_data write;
//   ar_valid/ar_address read request; r_valid/r_data/r_err read response.
// Build option: BRAM_WRAPPER_PIPE_FWD_EN gives write-first same-address collisions,
//   otherwise read-first.
module bram_wrapper_pipe #(
  parameter int    WIDTH        = 32,
  parameter int    DEPTH        = 1024,
  parameter int    LANE_WIDTH   = 8,
  parameter int    READ_LATENCY = 2,
  parameter string FABRIC       = "XILINX",
  localparam int   AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int   SW = (WIDTH + LANE_WIDTH - 1) / LANE_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w_valid,
  input  logic [AW-1:0]    w_address,
  input  logic [SW-1:0]    w_strb,
  input  logic [WIDTH-1:0] w_data,
  input  logic             ar_valid,
  input  logic [AW-1:0]    ar_address,
  output logic             r_valid,
  output logic [WIDTH-1:0] r_data,
  output logic             r_err
);

  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic             w_in;
  logic             ar_in;
  logic             w_en;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] mem_rd;
  logic [WIDTH-1:0] rd_d;

  assign w_in  = ({1'b0, w_address} < DEPTH_W);
  assign ar_in = ({1'b0, ar_address} < DEPTH_W);
  assign w_en  = w_valid & w_in;

  // Expand lane strobes to a bit mask; the top lane may be partial.
  for (genvar b = 0; b < WIDTH; b++) begin : g_wmask
    assign wmask[b] = w_strb[b / LANE_WIDTH];
  end

  if (FABRIC == "XILINX") begin : g_xil
    (* ram_style = "block" *)
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
      if (w_en) begin
        mem_q[w_address] <= (mem_q[w_address] & ~wmask)
                          | (w_data & wmask);
      end
    end

    assign mem_rd = mem_q[ar_address];
  end else begin : g_gen
    (* ramstyle = "no_rw_check" *)
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
      if (w_en) begin
        mem_q[w_address] <= (mem_q[w_address] & ~wmask)
                          | (w_data & wmask);
      end
    end

    assign mem_rd = mem_q[ar_address];
  end

`ifdef BRAM_WRAPPER_PIPE_FWD_EN
  logic fwd_hit;

  assign fwd_hit = w_en & (w_address == ar_address);

  // Struck lanes take the incoming word, the rest the stored word.
  always_comb begin
    rd_d = '0;
    if (ar_in) begin
      rd_d = mem_rd;
      if (fwd_hit) begin
        rd_d = (mem_rd & ~wmask) | (w_data & wmask);
      end
    end
  end
`else
  // The array updates on the same edge, so this is the pre-write word.
  always_comb begin
    rd_d = '0;
    if (ar_in) begin
      rd_d = mem_rd;
    end
  end
`endif

  logic [READ_LATENCY-1:0]            v_q;
  logic [READ_LATENCY-1:0]            v_d;
  logic [READ_LATENCY-1:0]            e_q;
  logic [READ_LATENCY-1:0]            e_d;
  logic [READ_LATENCY-1:0][WIDTH-1:0] d_q;
  logic [READ_LATENCY-1:0][WIDTH-1:0] d_d;

  assign v_d[0] = ar_valid;
  assign e_d[0] = ar_valid ? ~ar_in : e_q[0];
  assign d_d[0] = ar_valid ? rd_d   : d_q[0];

  // Data and error load only behind a valid, so r_data holds between pulses.
  for (genvar k = 1; k < READ_LATENCY; k++) begin : g_stage
    assign v_d[k] = v_q[k-1];
    assign e_d[k] = v_q[k-1] ? e_q[k-1] : e_q[k];
    assign d_d[k] = v_q[k-1] ? d_q[k-1] : d_q[k];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q <= '0;
      e_q <= '0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      e_q <= e_d;
      d_q <= d_d;
    end
  end

  assign r_valid = v_q[READ_LATENCY-1];
  assign r_err   = e_q[READ_LATENCY-1];
  assign r_data  = d_q[READ_LATENCY-1];

endmodule

// File: tb/tb_bram_wrapper_pipe.sv
// tb_bram_wrapper_pipe: four wrappers (READ_LATENCY 1..4, DEPTH 1000)
// on shared inputs, checked against a word-level memory model.
module tb_bram_wrapper_pipe;

  localparam int DEPTH = 1000;
  localparam int NL    = 4;
  localparam int HN    = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        w_valid = 1'b0;
  logic [9:0]  w_address = '0;
  logic [3:0]  w_strb = '0;
  logic [31:0] w_data = '0;
  logic        ar_valid = 1'b0;
  logic [9:0]  ar_address = '0;

  logic [NL-1:0]       rv;
  logic [NL-1:0]       re;
  logic [NL-1:0][31:0] rd;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    bram_wrapper_pipe #(
      .WIDTH(32), .DEPTH(DEPTH), .LANE_WIDTH(8),
      .READ_LATENCY(g + 1), .FABRIC("XILINX")
    ) u_dut (
      .clk(clk), .reset(rst_n),
      .w_valid(w_valid), .w_address(w_address),
      .w_strb(w_strb), .w_data(w_data),
      .ar_valid(ar_valid), .ar_address(ar_address),
      .r_valid(rv[g]), .r_data(rd[g]), .r_err(re[g])
    );
  end

  logic [31:0] mm [DEPTH];
  bit          mk [DEPTH];
  bit          hv [HN];
  logic [31:0] hd [HN];
  bit          he [HN];
  bit          hk [HN];
  logic [31:0] ld [NL];
  bit          lk [NL];
  int          pc [NL];
  int          ec = 0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n,
                                         logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit          w_ok;
    logic [31:0] v;
    bit          k;
    w_ok = rst_n && w_valid && (int'(w_address) < DEPTH);
    hv[ec] = 0;
    if (rst_n && ar_valid) begin
      hv[ec] = 1;
      if (int'(ar_address) >= DEPTH) begin
        hd[ec] = '0; he[ec] = 1; hk[ec] = 1;
      end else begin
        v = mm[ar_address];
        k = mk[ar_address];
`ifdef BRAM_WRAPPER_PIPE_FWD_EN
        if (w_ok && w_address == ar_address) begin
          v = merge(v, w_data, w_strb);
          k = k || (w_strb == 4'hF);
        end
`endif
        hd[ec] = v; he[ec] = 0; hk[ec] = k;
      end
    end
    if (w_ok) begin
      mm[w_address] = merge(mm[w_address], w_data, w_strb);
      mk[w_address] = mk[w_address] || (w_strb == 4'hF);
    end
    ec++;
  endtask

  task automatic check_outputs(int e);
    int src;
    bit ev;
    for (int g = 0; g < NL; g++) begin
      src = e - g;
      ev = (src >= 0) && hv[src];
      if (ev) begin
        ld[g] = hd[src];
        lk[g] = hk[src];
        pc[g]++;
      end
      chk($sformatf("r_valid L%0d edge%0d", g + 1, e), 32'(rv[g]), 32'(ev));
      if (ev)
        chk($sformatf("r_err L%0d edge%0d", g + 1, e), 32'(re[g]), 32'(he[src]));
      if (lk[g])
        chk($sformatf("r_data L%0d edge%0d", g + 1, e), rd[g], ld[g]);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(ec - 1);
  endtask

  task automatic idle();
    w_valid = 1'b0;
    ar_valid = 1'b0;
  endtask

  task automatic wr(int a, logic [31:0] d, logic [3:0] s);
    w_valid = 1'b1; w_address = 10'(a); w_data = d; w_strb = s;
    ar_valid = 1'b0;
    tick();
    idle();
  endtask

  task automatic rdreq(int a);
    ar_valid = 1'b1; ar_address = 10'(a);
    w_valid = 1'b0;
    tick();
    idle();
  endtask

  task automatic expect_read(string tag, logic [31:0] ed, bit ee);
    int n;
    n = 0;
    idle();
    while (!rv[1] && n < 8) begin
      tick();
      n++;
    end
    chk({tag, " seen"}, 32'(rv[1]), 32'd1);
    chk({tag, " data"}, rd[1], ed);
    chk({tag, " err"}, 32'(re[1]), 32'(ee));
  endtask

  task automatic clear_pc();
    for (int g = 0; g < NL; g++) pc[g] = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < NL; g++) begin
      chk($sformatf("rst r_valid L%0d", g + 1), 32'(rv[g]), 32'd0);
      chk($sformatf("rst r_data L%0d", g + 1), rd[g], 32'd0);
      chk($sformatf("rst r_err L%0d", g + 1), 32'(re[g]), 32'd0);
      ld[g] = '0;
      lk[g] = 1;
    end
    for (int i = 0; i < ec; i++) hv[i] = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] coll;
    int a;
    for (int g = 0; g < NL; g++) begin
      ld[g] = '0; lk[g] = 1; pc[g] = 0;
    end

    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int g = 0; g < NL; g++) begin
      chk($sformatf("idle r_valid L%0d", g + 1), 32'(rv[g]), 32'd0);
      chk($sformatf("idle r_data L%0d", g + 1), rd[g], 32'd0);
      chk($sformatf("idle r_err L%0d", g + 1), 32'(re[g]), 32'd0);
    end

    wr(5, 32'hDEADBEEF, 4'hF);
    rdreq(5);
    expect_read("rd5", 32'hDEADBEEF, 1'b0);

    wr(3, 32'h11223344, 4'hF);
    wr(3, 32'hAABBCCDD, 4'h5);
    rdreq(3);
    expect_read("partial", 32'h11BB33DD, 1'b0);

    wr(7, 32'h0, 4'hF);
    w_valid = 1'b1; w_address = 10'd7; w_data = 32'h12345678; w_strb = 4'hF;
    ar_valid = 1'b1; ar_address = 10'd7;
    tick();
`ifdef BRAM_WRAPPER_PIPE_FWD_EN
    coll = 32'h12345678;
`else
    coll = 32'h00000000;
`endif
    expect_read("collide", coll, 1'b0);
    rdreq(7);
    expect_read("after collide", 32'h12345678, 1'b0);

    wr(999, 32'h99999999, 4'hF);
    wr(1000, 32'hFFFFFFFF, 4'hF);
    wr(1023, 32'hFFFFFFFF, 4'hF);
    rdreq(1000);
    expect_read("oob1000", 32'h0, 1'b1);
    rdreq(999);
    expect_read("in999", 32'h99999999, 1'b0);
    rdreq(1023);
    expect_read("oob1023", 32'h0, 1'b1);

    for (int i = 0; i < 16; i++) wr(i, $urandom, 4'hF);
    tick();
    clear_pc();
    for (int i = 0; i < 16; i++) begin
      ar_valid = 1'b1; ar_address = 10'(i);
      tick();
    end
    idle();
    repeat (6) tick();
    for (int g = 0; g < NL; g++)
      chk($sformatf("burst pulses L%0d", g + 1), 32'(pc[g]), 32'd16);

    rdreq(20);
    ar_valid = 1'b1; ar_address = 10'd21;
    tick();
    do_reset();
    clear_pc();
    repeat (6) tick();
    for (int g = 0; g < NL; g++)
      chk($sformatf("post-reset pulses L%0d", g + 1), 32'(pc[g]), 32'd0);

    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 31)
                                     : $urandom_range(0, 1023);
      w_valid = 1'($urandom_range(0, 1));
      w_address = 10'(a);
      w_data = $urandom;
      w_strb = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      a = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 31)
                                     : $urandom_range(0, 1023);
      ar_valid = 1'($urandom_range(0, 1));
      ar_address = 10'(a);
      tick();
    end
    idle();
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_wrapper_pipe.md
# bram_wrapper_pipe

Parametrised single-clock simple-dual-port block-RAM wrapper with lane write strobes, a configurable registered read pipeline, out-of-range address protection and defined read-during-write behaviour. It sits between datapath logic and an inferred BRAM array. It replaces the fixed-latency wrapper wherever deeper read pipelining or partial writes are required.

## Interface
- WIDTH, 32: data word width in bits, ≥1.
- DEPTH, 1024: number of words, ≥2, need not be a power of two.
- LANE_WIDTH, 8: bits per write-strobe lane, 1..WIDTH.
- READ_LATENCY, 2: cycles from accepted read to r_valid, 1..4.
- FABRIC, "XILINX": target fabric string, passed to the RAM inference attribute only.

- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- w_valid  input  1  write request this cycle.
- w_address  input  AW  write word address, AW = max(1, $clog2(DEPTH)).
- w_strb  input  SW  per-lane write enable, SW = ceil(WIDTH/LANE_WIDTH); the last lane may be partial.
- w_data  input  WIDTH  write data.
- ar_valid  input  1  read request this cycle.
- ar_address  input  AW  read word address.
- r_valid  output  1  read data valid, one pulse per accepted read.
- r_data  output  WIDTH  read data.
- r_err  output  1  qualified by r_valid; the read address was ≥ DEPTH.

## Operation
- There is no backpressure. Every cycle with ar_valid high is an accepted read. Every cycle with w_valid high is an accepted write.
- Write: on the rising edge with w_valid=1 and w_address<DEPTH, update each lane i with w_strb[i]=1 from w_data. Lanes with w_strb[i]=0 keep their value.
  - w_strb=0 is a legal no-op.
  - A write with w_address≥DEPTH is discarded; the array is unchanged.
- Read: stage 1 registers the array word at ar_address and the out-of-range flag. Stages 2..READ_LATENCY are pure registers.
  - An out-of-range read returns r_data=0 with r_err=1.
- Valid pipeline: a READ_LATENCY-deep shift register of ar_valid. The r_err flag travels alongside it.
- Data registers load only when their stage valid is high. r_data holds its last value while r_valid=0.
- Array contents are not reset and are undefined until written.
- Back-to-back reads at any address, one per cycle, give full throughput.

## Timing
- A read accepted at cycle t produces r_valid=1 at cycle t+READ_LATENCY, with its data and r_err.
- A write at cycle t is visible to a read accepted at t+1 or later.
- Same-cycle read and write to the same in-range address follows Configuration.
- Reset asserted, asynchronously: r_valid=0, r_data=0, r_err=0, and all pipeline valid bits are 0.
  - In-flight reads are dropped and never return.
  - A write on the edge where reset is asserted is not guaranteed.
- Reset deassertion is synchronised by the caller. The first accepted request is on the first edge after release.
- Address wrap is not performed. Addresses ≥DEPTH are handled as above, including the 2^AW−1 boundary.

## Configuration
- BRAM_WRAPPER_PIPE_FWD_EN defined: same-cycle read and write to the same in-range address returns write-first data.
  - Per lane, the new w_data is used where w_strb[i]=1 and the old array value elsewhere.
  - This uses a registered forwarding mux at stage 1.
- Macro undefined: read-first. The read returns the pre-write contents, and no forwarding logic is built.

## Test plan
- Reset then idle: after release, r_valid, r_data and r_err all read 0. Then write 0xDEADBEEF to address 5 with w_strb=0xF, and read address 5 one cycle later. Required: r_valid at +READ_LATENCY with r_data=0xDEADBEEF and r_err=0.
- Partial write: address 3 holds 0x11223344; write 0xAABBCCDD with w_strb=0x5. Required: a read returns 0x11BB33DD.
- Same-cycle collision: address 7 holds 0x0; write 0x12345678 (strb 0xF) and read 7 in the same cycle. Required: 0x12345678 with the macro defined, 0x00000000 without.
- Out of range, DEPTH=1000, AW=10: write 0xFFFFFFFF to 1000 and 1023, then read 1000. Required: r_data=0 and r_err=1. A read of 999 is unaffected.
- Throughput and reset for READ_LATENCY 1..4: read addresses 0..15 back-to-back. Required: 16 consecutive r_valid pulses in order. Assert reset with 2 reads in flight. Required: zero r_valid pulses after release and outputs at 0.
